// File: rtl/dram_arbiter.sv
// Shares the DRAM controller's single cycle-request port among CPU, DMA and CBR refresh.
// Grants register one edge after REQ is sampled in IDLE; requesters wait on GNT, refresh defers up to MAX_DEFER.
module dram_arbiter #(
  parameter int REFRESH_INTERVAL = 375,
  parameter int MAX_DEFER        = 4,
  parameter int URGENT_LEVEL     = 2,
  parameter int CPU_STREAK_MAX   = 3
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       CPU_REQ,
  output logic       CPU_GNT,
  output logic       CPU_DONE,
  input  logic       DMA_REQ,
  output logic       DMA_GNT,
  output logic       DMA_DONE,
  output logic       MEM_START,
  output logic       MEM_REFRESH,
  output logic       MEM_OWNER,
  input  logic       MEM_DONE,
  output logic [2:0] REFRESH_OWED,
  output logic       REFRESH_OVERRUN
);

  localparam logic [11:0] TICK_AT     = 12'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]  OWED_MAX    = 3'(MAX_DEFER);
  localparam logic [2:0]  OWED_URGENT = 3'(URGENT_LEVEL);
  localparam logic [3:0]  STREAK_MAX  = 4'(CPU_STREAK_MAX);

  typedef enum logic [1:0] {IDLE, CYCLE, RELEASE} state_t;

  state_t      state, state_n;
  logic [11:0] timer;
  logic [3:0]  streak, streak_n;
  logic [2:0]  owed_n;
  logic        overrun_n;
  logic        tick, ref_grant;
  logic        cpu_gnt_n, dma_gnt_n, mem_refresh_n, mem_owner_n;
  logic        mem_start_n, cpu_done_n, dma_done_n;

  assign tick = (timer == TICK_AT);

  always_comb begin
    state_n       = state;
    streak_n      = streak;
    cpu_gnt_n     = CPU_GNT;
    dma_gnt_n     = DMA_GNT;
    mem_refresh_n = MEM_REFRESH;
    mem_owner_n   = MEM_OWNER;
    mem_start_n   = 1'b0;
    cpu_done_n    = 1'b0;
    dma_done_n    = 1'b0;
    ref_grant     = 1'b0;

    case (state)
      IDLE: begin
        if (!DMA_REQ) streak_n = '0;
        if (REFRESH_OWED >= OWED_URGENT) begin
          ref_grant = 1'b1;
        end else if (DMA_REQ && streak == STREAK_MAX) begin
          dma_gnt_n   = 1'b1;
          mem_owner_n = 1'b1;
          streak_n    = '0;
        end else if (CPU_REQ) begin
          cpu_gnt_n   = 1'b1;
          mem_owner_n = 1'b0;
          if (DMA_REQ && streak != STREAK_MAX) streak_n = streak + 4'd1;
        end else if (DMA_REQ) begin
          dma_gnt_n   = 1'b1;
          mem_owner_n = 1'b1;
          streak_n    = '0;
        end else if (REFRESH_OWED != 3'd0) begin
          ref_grant = 1'b1;
        end
        if (ref_grant) mem_refresh_n = 1'b1;
        if (ref_grant || cpu_gnt_n || dma_gnt_n) begin
          mem_start_n = 1'b1;
          state_n     = CYCLE;
        end
      end
      CYCLE: begin
        if (MEM_DONE) begin
          cpu_done_n    = CPU_GNT;
          dma_done_n    = DMA_GNT;
          cpu_gnt_n     = 1'b0;
          dma_gnt_n     = 1'b0;
          mem_refresh_n = 1'b0;
          state_n       = RELEASE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A tick and a refresh grant on the same edge cancel out.
    owed_n    = REFRESH_OWED;
    overrun_n = REFRESH_OVERRUN;
    if (tick && !ref_grant) begin
      if (REFRESH_OWED == OWED_MAX) overrun_n = 1'b1;
      else                          owed_n    = REFRESH_OWED + 3'd1;
    end else if (!tick && ref_grant) begin
      owed_n = REFRESH_OWED - 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state           <= IDLE;
      timer           <= '0;
      streak          <= '0;
      CPU_GNT         <= 1'b0;
      CPU_DONE        <= 1'b0;
      DMA_GNT         <= 1'b0;
      DMA_DONE        <= 1'b0;
      MEM_START       <= 1'b0;
      MEM_REFRESH     <= 1'b0;
      MEM_OWNER       <= 1'b0;
      REFRESH_OWED    <= '0;
      REFRESH_OVERRUN <= 1'b0;
    end else begin
      state           <= state_n;
      timer           <= tick ? 12'd0 : timer + 12'd1;
      streak          <= streak_n;
      CPU_GNT         <= cpu_gnt_n;
      CPU_DONE        <= cpu_done_n;
      DMA_GNT         <= dma_gnt_n;
      DMA_DONE        <= dma_done_n;
      MEM_START       <= mem_start_n;
      MEM_REFRESH     <= mem_refresh_n;
      MEM_OWNER       <= mem_owner_n;
      REFRESH_OWED    <= owed_n;
      REFRESH_OVERRUN <= overrun_n;
    end
  end

endmodule
